// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// State encoding and counter-width calculation live here.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH = 8;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH);

    // Bit-counter width for a given operand width (never below 1).
    function automatic int cnt_width(input int w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow out.
// Purely combinational; the serial datapath reuses it every cycle.
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i ^ bi_i;
    assign bo_o = (~x_i & y_i) | (~x_i & bi_i) | (y_i & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// start/done handshake; results held until the next accept.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] r_sr_q;
    logic [WIDTH-1:0] r_sr_d;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    full_subtractor u_fs (
        .x_i  (a_sr_q[0]),
        .y_i  (b_sr_q[0]),
        .bi_i (brw_q),
        .d_o  (cell_d),
        .bo_o (cell_bo)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Result register after this cycle's bit shifts into the MSB.
    always_comb begin
        r_sr_d = {cell_d, r_sr_q[WIDTH-1:1]};
    end

    // Control FSM, operand/result shifters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        brw_q   <= bin;
                        r_sr_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    r_sr_q <= r_sr_d;
                    brw_q  <= cell_bo;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_bit) begin
                        // brw_q is the borrow into the MSB here.
                        diff_q  <= r_sr_d;
                        bout_q  <= cell_bo;
                        ovf_q   <= brw_q ^ cell_bo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
